// File: rtl/cell_eval_engine.sv
// rtl/cell_eval_engine.sv - evaluates mapped standard-cell records against a net-value array
// Optional statistics counters enabled by defining CELL_EVAL_STATS_EN.
module cell_eval_engine #(
    parameter int NET_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [NET_W-1:0] in_a,
    input  logic [NET_W-1:0] in_b,
    input  logic [NET_W-1:0] in_c,
    input  logic [NET_W-1:0] in_d,
    input  logic [NET_W-1:0] in_e,
    input  logic [NET_W-1:0] in_f,
    input  logic [NET_W-1:0] in_dst,
    output logic             out_valid,
    output logic [NET_W-1:0] out_net,
    output logic             out_val,
    input  logic [NET_W-1:0] rd_addr,
    output logic             rd_data,
    output logic             err,
    output logic [CNT_W-1:0] cnt_eval,
    output logic [CNT_W-1:0] cnt_tick
);
    localparam int NNETS = 2 ** NET_W;

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t             state_q, state_d;
    logic [4:0]         op_q, op_d;
    logic [NET_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, e_q, e_d, f_q, f_d, dst_q, dst_d;
    logic [NNETS-1:0]   net_q, net_d, next_q, next_d, mask_q, mask_d;
    logic               err_q, err_d, rd_data_q, rd_data_d;
    logic               out_valid_q, out_valid_d, out_val_q, out_val_d;
    logic [NET_W-1:0]   out_net_q, out_net_d;
    logic               va, vb, vc, vd, ve, vf, vcur, res, tick_hit;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q; e_d = e_q; f_d = f_q; dst_d = dst_q;
        net_d       = net_q;
        next_d      = next_q;
        mask_d      = mask_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        out_net_d   = out_net_q;
        out_val_d   = out_val_q;
        rd_data_d   = net_q[rd_addr];
        tick_hit    = 1'b0;
        va = net_q[a_q]; vb = net_q[b_q]; vc = net_q[c_q];
        vd = net_q[d_q]; ve = net_q[e_q]; vf = net_q[f_q];
        vcur = net_q[dst_q];

        res = 1'b0;
        case (op_q)
            5'd0:  res = ~va;
            5'd1:  res = ~(va & vb);
            5'd2:  res = ~(va | vb);
            5'd3:  res = va & vb;
            5'd4:  res = va | vb;
            5'd5:  res = va ^ vb;
            5'd6:  res = ~(va ^ vb);
            5'd7:  res = ~(va & vb & vc);
            5'd8:  res = ~(va | vb | vc);
            5'd9:  res = va & vb & vc;
            5'd10: res = va | vb | vc;
            5'd11: res = ~((va & vb) | vc);
            5'd12: res = ~((va | vb) & vc);
            5'd13: res = ~((va & vb) | (vc & vd));
            5'd14: res = ~((va | vb) & (vc | vd));
            5'd15: res = ~(va & vb & vc & vd);
            5'd16: res = ~(va | vb | vc | vd);
            5'd17: res = va & vb & vc & vd;
            5'd18: res = va | vb | vc | vd;
            5'd19: res = vc ? vb : va;
            5'd20: begin
                case ({vf, ve})
                    2'b00:   res = va;
                    2'b01:   res = vb;
                    2'b10:   res = vc;
                    default: res = vd;
                endcase
            end
            5'd21: res = vb ? 1'b0 : va;
            // DFFE with enable low holds the current net value as its next state
            5'd22: res = vb ? 1'b0 : (vc ? va : vcur);
            5'd23: res = a_q[0];
            default: res = 1'b0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = in_op;
                    a_d = in_a; b_d = in_b; c_d = in_c; d_d = in_d;
                    e_d = in_e; f_d = in_f; dst_d = in_dst;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                if (op_q <= 5'd20 || op_q == 5'd23) begin
                    net_d[dst_q] = res;
                end else if (op_q == 5'd21 || op_q == 5'd22) begin
                    next_d[dst_q] = res;
                    mask_d[dst_q] = 1'b1;
                end else if (op_q == 5'd24) begin
                    net_d    = (net_q & ~mask_q) | (next_q & mask_q);
                    tick_hit = 1'b1;
                end else if (op_q == 5'd25) begin
                    net_d  = '0;
                    next_d = '0;
                    mask_d = '0;
                end else begin
                    err_d = 1'b1;
                end
                if (op_q <= 5'd23) begin
                    out_valid_d = 1'b1;
                    out_net_d   = dst_q;
                    out_val_d   = res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            op_q <= '0; a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
            e_q <= '0; f_q <= '0; dst_q <= '0;
            net_q <= '0; next_q <= '0; mask_q <= '0;
            err_q <= 1'b0; rd_data_q <= 1'b0;
            out_valid_q <= 1'b0; out_net_q <= '0; out_val_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d; a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
            e_q <= e_d; f_q <= f_d; dst_q <= dst_d;
            net_q <= net_d; next_q <= next_d; mask_q <= mask_d;
            err_q <= err_d; rd_data_q <= rd_data_d;
            out_valid_q <= out_valid_d; out_net_q <= out_net_d; out_val_q <= out_val_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_net   = out_net_q;
    assign out_val   = out_val_q;
    assign rd_data   = rd_data_q;
    assign err       = err_q;

`ifdef CELL_EVAL_STATS_EN
    logic [CNT_W-1:0] cnt_eval_q, cnt_eval_d, cnt_tick_q, cnt_tick_d;

    // Saturating counters; CLR leaves them alone, only RST clears
    always_comb begin
        cnt_eval_d = cnt_eval_q;
        cnt_tick_d = cnt_tick_q;
        if (out_valid_d && cnt_eval_q != {CNT_W{1'b1}}) cnt_eval_d = cnt_eval_q + 1'b1;
        if (tick_hit && cnt_tick_q != {CNT_W{1'b1}})    cnt_tick_d = cnt_tick_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_eval_q <= '0;
            cnt_tick_q <= '0;
        end else begin
            cnt_eval_q <= cnt_eval_d;
            cnt_tick_q <= cnt_tick_d;
        end
    end

    assign cnt_eval = cnt_eval_q;
    assign cnt_tick = cnt_tick_q;
`else
    logic unused_stats;
    assign unused_stats = tick_hit;
    assign cnt_eval     = '0;
    assign cnt_tick     = '0;
`endif
endmodule

// File: tb/tb_cell_eval_engine.sv
// tb/tb_cell_eval_engine.sv - scoreboard bench for cell_eval_engine
module tb_cell_eval_engine;
    localparam int NET_W = 6;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       in_op = '0;
    logic [NET_W-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0, in_e = '0, in_f = '0, in_dst = '0;
    logic             out_valid;
    logic [NET_W-1:0] out_net;
    logic             out_val;
    logic [NET_W-1:0] rd_addr = '0;
    logic             rd_data;
    logic             err;
    logic [CNT_W-1:0] cnt_eval, cnt_tick;

    int checks = 0;
    int errors = 0;
    int ov_cnt = 0;
    int last_busy = 0;

    logic [6:0] sb_q[$];
    logic       m_net[64];
    logic       m_next[64];
    logic       m_mask[64];

    cell_eval_engine #(.NET_W(NET_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e), .in_f(in_f),
        .in_dst(in_dst), .out_valid(out_valid), .out_net(out_net), .out_val(out_val),
        .rd_addr(rd_addr), .rd_data(rd_data), .err(err), .cnt_eval(cnt_eval), .cnt_tick(cnt_tick)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!RST && out_valid) begin
            logic [6:0] exp_v;
            ov_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got net=%0d val=%0d, expected no output", out_net, out_val);
            end else begin
                exp_v = sb_q.pop_front();
                if ({out_net, out_val} !== exp_v) begin
                    errors++;
                    $display("FAIL out_result: got net=%0d val=%0d, expected net=%0d val=%0d",
                             out_net, out_val, exp_v[6:1], exp_v[0]);
                end
            end
        end
    end

    function automatic logic cell_fn(input int op, input logic a, b, c, d, e, f, cur);
        logic [1:0] s;
        s = {f, e};
        case (op)
            0:  return !a;
            1:  return !(a && b);
            2:  return !(a || b);
            3:  return a && b;
            4:  return a || b;
            5:  return a != b;
            6:  return a == b;
            7:  return !(a && b && c);
            8:  return !(a || b || c);
            9:  return a && b && c;
            10: return a || b || c;
            11: return !((a && b) || c);
            12: return !((a || b) && c);
            13: return !((a && b) || (c && d));
            14: return !((a || b) && (c || d));
            15: return !(a && b && c && d);
            16: return !(a || b || c || d);
            17: return a && b && c && d;
            18: return a || b || c || d;
            19: return c ? b : a;
            20: return (s == 2'd0) ? a : (s == 2'd1) ? b : (s == 2'd2) ? c : d;
            21: return b ? 1'b0 : a;
            22: return b ? 1'b0 : (!c ? cur : a);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int num_inputs(input int op);
        if (op == 0) return 1;
        if (op <= 6) return 2;
        if (op <= 12 || op == 19) return 3;
        if (op <= 18) return 4;
        return 6;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_net[i] = 1'b0; m_next[i] = 1'b0; m_mask[i] = 1'b0;
        end
    endtask

    task automatic send(input int op, input int a, b, c, d, e, f, dst);
        int w;
        logic v;
        w = 0;
        while (!in_ready && w < 20) begin @(negedge CLK); w++; end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0d, expected 1", in_ready);
        end
        in_op = op[4:0]; in_a = a[5:0]; in_b = b[5:0]; in_c = c[5:0];
        in_d = d[5:0]; in_e = e[5:0]; in_f = f[5:0]; in_dst = dst[5:0];
        in_valid = 1'b1;
        if (op <= 20 || op == 21 || op == 22) begin
            v = cell_fn(op, m_net[a], m_net[b], m_net[c], m_net[d], m_net[e], m_net[f], m_net[dst]);
            sb_q.push_back({dst[5:0], v});
            if (op <= 20) m_net[dst] = v;
            else begin m_next[dst] = v; m_mask[dst] = 1'b1; end
        end else if (op == 23) begin
            sb_q.push_back({dst[5:0], a[0]});
            m_net[dst] = a[0];
        end else if (op == 24) begin
            for (int i = 0; i < 64; i++) if (m_mask[i]) m_net[i] = m_next[i];
        end else if (op == 25) begin
            model_clear();
        end
        @(posedge CLK);
        #1 in_valid = 1'b0;
        last_busy = 0;
        @(negedge CLK);
        while (!in_ready && last_busy < 20) begin last_busy++; @(negedge CLK); end
    endtask

    task automatic set_net(input int n, input int v);
        send(23, v, 0, 0, 0, 0, 0, n);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb_q.size() != 0 || !in_ready) && w < 50) begin @(negedge CLK); w++; end
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic read_net(input int n, input logic exp_v, input string name);
        rd_addr = n[5:0];
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (rd_data !== exp_v) begin
            errors++;
            $display("FAIL %s: rd_data[%0d]=%0d, expected %0d", name, n, rd_data, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        sb_q.delete();
        model_clear();
        @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_net !== '0 || out_val !== 1'b0 ||
            rd_data !== 1'b0 || err !== 1'b0 || cnt_eval !== '0 || cnt_tick !== '0) begin
            errors++;
            $display("FAIL %s: rdy=%0d ov=%0d net=%0d val=%0d rd=%0d err=%0d ce=%0d ct=%0d, expected 1 0 0 0 0 0 0 0",
                     name, in_ready, out_valid, out_net, out_val, rd_data, err, cnt_eval, cnt_tick);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset_state");
        set_net(1, 1);
        set_net(2, 0);
        send(1, 1, 2, 0, 0, 0, 0, 3);
        checks++;
        if (last_busy !== 1) begin
            errors++;
            $display("FAIL ready_low_cycles: got %0d, expected 1", last_busy);
        end
        drain();
        read_net(3, 1'b1, "nand2_readback");
    endtask

    task automatic test_truth_tables();
        for (int op = 0; op <= 20; op++) begin
            int n;
            n = num_inputs(op);
            for (int v = 0; v < (1 << n); v++) begin
                for (int k = 0; k < n; k++) set_net(10 + k, (v >> k) & 1);
                send(op, 10, 11, 12, 13, 14, 15, 20);
            end
        end
        drain();
        set_net(10, 0); set_net(11, 0); set_net(12, 1); set_net(13, 0);
        set_net(14, 0); set_net(15, 1);
        send(20, 10, 11, 12, 13, 14, 15, 21);
        drain();
        read_net(21, 1'b1, "mux4_sel_c");
    endtask

    task automatic test_dff();
        set_net(0, 0); set_net(7, 0); set_net(5, 1);
        send(21, 5, 0, 0, 0, 0, 0, 6);
        drain();
        read_net(6, 1'b0, "dff_before_tick");
        send(24, 0, 0, 0, 0, 0, 0, 0);
        drain();
        read_net(6, 1'b1, "dff_after_tick");
        set_net(5, 0);
        send(22, 5, 0, 7, 0, 0, 0, 6);
        send(24, 0, 0, 0, 0, 0, 0, 0);
        drain();
        read_net(6, 1'b1, "dffe_hold");
        set_net(8, 1); set_net(5, 1);
        send(21, 5, 8, 0, 0, 0, 0, 6);
        send(24, 0, 0, 0, 0, 0, 0, 0);
        drain();
        read_net(6, 1'b0, "dff_reset_net");
    endtask

    task automatic test_illegal();
        int ov_before;
        set_net(30, 1);
        drain();
        ov_before = ov_cnt;
        send(27, 0, 0, 0, 0, 0, 0, 30);
        drain();
        repeat (2) @(negedge CLK);
        checks++;
        if (ov_cnt !== ov_before || err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op: outputs=%0d err=%0d, expected 0 outputs err=1", ov_cnt - ov_before, err);
        end
        read_net(30, 1'b1, "illegal_no_write");
        send(25, 0, 0, 0, 0, 0, 0, 0);
        drain();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_after_clr: err=%0d, expected 1", err);
        end
        read_net(30, 1'b0, "clr_nets");
        do_reset();
        check_reset_outputs("err_cleared_by_rst");
    endtask

    task automatic test_reset_mid_exec();
        set_net(1, 1);
        set_net(2, 1);
        drain();
        rd_addr = 6'd2;
        in_op = 5'd3; in_a = 6'd1; in_b = 6'd2; in_dst = 6'd9; in_valid = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0; RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        sb_q.delete();
        model_clear();
        @(negedge CLK);
        check_reset_outputs("rst_mid_exec_outputs");
        repeat (2) @(negedge CLK);
        read_net(9, 1'b0, "rst_mid_exec_n9");
        read_net(1, 1'b0, "rst_mid_exec_n1");
    endtask

    task automatic test_stats();
        logic [CNT_W-1:0] exp_e, exp_t;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_net(40 + i, i & 1);
            if (i == 2 || i == 5 || i == 8) send(24, 0, 0, 0, 0, 0, 0, 0);
        end
        drain();
`ifdef CELL_EVAL_STATS_EN
        exp_e = 16'd10; exp_t = 16'd3;
`else
        exp_e = 16'd0; exp_t = 16'd0;
`endif
        checks++;
        if (cnt_eval !== exp_e || cnt_tick !== exp_t) begin
            errors++;
            $display("FAIL stats: cnt_eval=%0d cnt_tick=%0d, expected %0d %0d", cnt_eval, cnt_tick, exp_e, exp_t);
        end
    endtask

    initial begin
        test_reset();
        test_truth_tables();
        test_dff();
        test_illegal();
        test_reset_mid_exec();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
